// File: rtl/fifo_seq_consumer.sv
// fifo_seq_consumer
// Drains a synchronous FIFO (empty/rd_en interface, one-cycle read latency) and
// checks that the words received form an incrementing sequence starting at
// START_VALUE. After EXPECT_COUNT words it reports done/pass and holds its counters.
// Optional watchdog: define FIFO_CONSUMER_TIMEOUT_EN to abort a run that has seen
// no read for TIMEOUT_CYCLES cycles.
//
// Handshake: a word is taken on a rising edge where fifo_rd_en=1. fifo_rd_en is
// raised only while fifo_empty=0, and the word is presented on fifo_dout during
// the cycle after the strobe. One word per cycle can be taken.
module fifo_seq_consumer #(
    parameter int DATA_WIDTH     = 32,
    parameter int EXPECT_COUNT   = 6,
    parameter int START_VALUE    = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           rx_count,
    output logic [15:0]           err_count,
    output logic [DATA_WIDTH-1:0] last_data,
    output logic                  timeout,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [DATA_WIDTH-1:0] START_WORD = DATA_WIDTH'(START_VALUE);
    localparam logic [15:0]           LAST_ISSUE = 16'(EXPECT_COUNT - 1);

    // Reject configurations the 16-bit counters cannot represent.
    if (EXPECT_COUNT < 1 || EXPECT_COUNT > 65535 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("fifo_seq_consumer: EXPECT_COUNT and TIMEOUT_CYCLES must be 1..65535");
    end

    logic [1:0]            state;
    logic [15:0]           issued;
    logic                  pending;
    logic [DATA_WIDTH-1:0] expected;
    logic                  start_ok;
    logic                  idle_expired;

    // start only counts when no run is in progress.
    assign start_ok = start && (state == S_IDLE || state == S_DONE);

    // Read strobe: only in RUN, only with data available, never more than EXPECT_COUNT.
    always_comb begin
        fifo_rd_en = (state == S_RUN) && !fifo_empty && (issued < 16'(EXPECT_COUNT));
    end

    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign pass      = done && (err_count == 16'd0) && !timeout;
    assign state_dbg = state;

`ifdef FIFO_CONSUMER_TIMEOUT_EN
    logic [15:0] idle_cnt;

    assign idle_expired = (state == S_RUN) && (idle_cnt == 16'(TIMEOUT_CYCLES));

    // Idle watchdog: counts RUN cycles since the last read or since the run began.
    always_ff @(posedge clk) begin
        if (reset || start_ok || fifo_rd_en || state != S_RUN) begin
            idle_cnt <= 16'd0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign idle_expired = 1'b0;
`endif

    // Run control, read bookkeeping and the sequence checker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            issued    <= 16'd0;
            pending   <= 1'b0;
            expected  <= START_WORD;
            rx_count  <= 16'd0;
            err_count <= 16'd0;
            last_data <= '0;
            timeout   <= 1'b0;
        end else begin
            // The word read last cycle is on fifo_dout now.
            pending <= fifo_rd_en;

            // Check the returned word; expected always advances so one bad word is one error.
            if (pending) begin
                rx_count  <= rx_count + 16'd1;
                last_data <= fifo_dout;
                expected  <= expected + 1'b1;
                if (fifo_dout != expected && err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end

            case (state)
                S_RUN: begin
                    if (fifo_rd_en) begin
                        issued <= issued + 16'd1;
                    end
                    if (idle_expired) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end else if (fifo_rd_en && issued == LAST_ISSUE) begin
                        state <= S_DRAIN;
                    end
                end
                // No reads are issued here, so the last word is checked on this edge.
                S_DRAIN: state <= S_DONE;
                default: ;
            endcase

            // A new run starts from a clean slate (IDLE or DONE only).
            if (start_ok) begin
                state     <= S_RUN;
                issued    <= 16'd0;
                expected  <= START_WORD;
                rx_count  <= 16'd0;
                err_count <= 16'd0;
                last_data <= '0;
                timeout   <= 1'b0;
            end
        end
    end

endmodule
